pipe_skid_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_skid_reg_sat_counter.sv | 34 +++
 rtl/pipe_skid_reg.sv | 105 ++++++++++
 tb/tb_pipe_skid_reg.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage registers.
// Holds the F/D bubble payload and the skid-buffer state encoding.
package pipe_pkg;

    localparam logic [31:0] RV32_NOP = 32'h00000013;

    localparam int          FD_DATA_W     = 96;
    localparam logic [95:0] FD_BUBBLE_VAL = {64'h0, RV32_NOP};

    // Encoding value 3 is unused; the stage FSM recovers from it to ST_EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register: valid/ready handshake with a two-entry skid
// buffer so in_ready is a flop, plus flush and a back-pressure stall counter.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W     = FD_DATA_W,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = DATA_W'(FD_BUBBLE_VAL),
    parameter int                 CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    pipe_state_e       state_q;
    logic              out_valid_q;
    logic              in_ready_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // Payload registers are returned to BUBBLE_VAL whenever they go invalid,
    // so out_data needs no output mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_q      <= BUBBLE_VAL;
            skid_q      <= BUBBLE_VAL;
        end else if (flush) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_q      <= BUBBLE_VAL;
            skid_q      <= BUBBLE_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_q      <= in_data;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= in_data;
                    end else if (in_xfer) begin
                        skid_q     <= in_data;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_SKID;
                    end else if (out_xfer) begin
                        main_q      <= BUBBLE_VAL;
                        out_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        main_q     <= skid_q;
                        skid_q     <= BUBBLE_VAL;
                        in_ready_q <= 1'b1;
                        state_q    <= ST_FULL;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    main_q      <= BUBBLE_VAL;
                    skid_q      <= BUBBLE_VAL;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid_q & ~out_ready & ~flush),
        .clr (stall_clr),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, hand-written corner cases and
// a randomized run against a queue-based reference model.
module tb_pipe_skid_reg;

    localparam int          DW  = 96;
    localparam logic [95:0] BUB = {64'h0, 32'h00000013};

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          stall_clr;

    logic          in_ready, in_ready4;
    logic          out_valid, out_valid4;
    logic [DW-1:0] out_data, out_data4;
    logic [15:0]   stall_cnt;
    logic [3:0]    stall_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_skid_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr)
    );

    pipe_skid_reg #(.CNT_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .in_data   (in_data),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .out_data  (out_data4),
        .stall_cnt (stall_cnt4),
        .stall_clr (stall_clr)
    );

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; in_data = '0; out_ready = 0; stall_clr = 0;
    endtask

    typedef struct {
        logic          fl;
        logic          iv;
        logic [95:0]   d;
        logic          ordy;
        logic          clr;
        logic          ev;
        logic          eir;
        logic [95:0]   ed;
        int unsigned   es;
    } vec_t;

    vec_t vq[$];

    // Reference model: an ordered list of held payloads, capacity two.
    logic [95:0] mq[$];
    int unsigned m_cnt, m_cnt4;

    initial begin
        idle_inputs();
        rst = 1;
        #12;
        chk("rst_out_valid", 96'(out_valid), 96'(0));
        chk("rst_out_data",  out_data, BUB);
        chk("rst_in_ready",  96'(in_ready), 96'(1));
        chk("rst_stall_cnt", 96'(stall_cnt), 96'(0));
        in_valid = 1; in_data = 96'hDEAD; out_ready = 0;
        cyc();
        chk("rst_ignores_hs", 96'(out_valid), 96'(0));
        chk("rst_ignores_data", out_data, BUB);
        @(negedge clk);
        idle_inputs();
        rst = 0;

        // flush, in_valid, in_data, out_ready, stall_clr | out_valid, in_ready, out_data, stall_cnt
        for (int i = 0; i < 8; i++)
            vq.push_back(vec_t'{0, 1, 96'(8'h11 + i), 1, 0, 1, 1, 96'(8'h11 + i), 0});
        vq.push_back(vec_t'{0, 0, 96'h0,  1, 0, 0, 1, BUB,    0});
        vq.push_back(vec_t'{0, 1, 96'hA0, 0, 0, 1, 1, 96'hA0, 0});
        vq.push_back(vec_t'{0, 1, 96'hB0, 0, 0, 1, 0, 96'hA0, 1});
        vq.push_back(vec_t'{0, 0, 96'h0,  0, 0, 1, 0, 96'hA0, 2});
        vq.push_back(vec_t'{0, 0, 96'h0,  1, 0, 1, 1, 96'hB0, 2});
        vq.push_back(vec_t'{0, 0, 96'h0,  1, 0, 0, 1, BUB,    2});
        vq.push_back(vec_t'{0, 1, 96'hA1, 0, 0, 1, 1, 96'hA1, 2});
        vq.push_back(vec_t'{0, 1, 96'hB1, 0, 0, 1, 0, 96'hA1, 3});
        vq.push_back(vec_t'{1, 1, 96'hC1, 0, 0, 0, 1, BUB,    3});
        vq.push_back(vec_t'{0, 0, 96'h0,  1, 0, 0, 1, BUB,    3});
        vq.push_back(vec_t'{0, 0, 96'h0,  1, 1, 0, 1, BUB,    0});

        #1;
        for (int i = 0; i < vq.size(); i++) begin
            flush = vq[i].fl; in_valid = vq[i].iv; in_data = vq[i].d;
            out_ready = vq[i].ordy; stall_clr = vq[i].clr;
            cyc();
            $display("vec %0d: in_valid=%0b in_data=%h out_valid=%0b in_ready=%0b out_data=%h stall_cnt=%0d",
                     i, vq[i].iv, vq[i].d, out_valid, in_ready, out_data, stall_cnt);
            chk($sformatf("vec%0d_out_valid", i), 96'(out_valid), 96'(vq[i].ev));
            chk($sformatf("vec%0d_in_ready", i),  96'(in_ready),  96'(vq[i].eir));
            chk($sformatf("vec%0d_out_data", i),  out_data, vq[i].ed);
            chk($sformatf("vec%0d_stall_cnt", i), 96'(stall_cnt), 96'(vq[i].es));
        end
        idle_inputs();

        // Asynchronous reset while holding two entries.
        in_valid = 1; in_data = 96'hE1; cyc();
        in_data = 96'hE2; cyc();
        in_valid = 0;
        chk("skid_in_ready", 96'(in_ready), 96'(0));
        #3;
        rst = 1;
        #1;
        $display("async rst in SKID: out_valid=%0b in_ready=%0b stall_cnt=%0d", out_valid, in_ready, stall_cnt);
        chk("arst_out_valid", 96'(out_valid), 96'(0));
        chk("arst_in_ready",  96'(in_ready), 96'(1));
        chk("arst_out_data",  out_data, BUB);
        chk("arst_stall_cnt", 96'(stall_cnt), 96'(0));
        @(negedge clk);
        rst = 0;

        // Saturation on the 4-bit counter instance.
        in_valid = 1; in_data = 96'h55; out_ready = 0; cyc();
        in_valid = 0;
        repeat (20) cyc();
        $display("saturation: stall_cnt4=%0d stall_cnt16=%0d", stall_cnt4, stall_cnt);
        chk("sat_cnt4",  96'(stall_cnt4), 96'(15));
        chk("sat_cnt16", 96'(stall_cnt),  96'(20));
        stall_clr = 1; cyc(); stall_clr = 0;
        chk("clr_cnt4",  96'(stall_cnt4), 96'(0));
        chk("clr_cnt16", 96'(stall_cnt),  96'(0));

        #2 rst = 1;
        #2 rst = 0;
        mq.delete();
        m_cnt = 0; m_cnt4 = 0;
        idle_inputs();

        for (int c = 0; c < 10000; c++) begin
            logic m_ov, m_ir, push, pop;
            logic [95:0] m_od;
            flush     = ($urandom_range(99) < 4);
            stall_clr = ($urandom_range(99) < 2);
            in_valid  = ($urandom_range(99) < 60);
            out_ready = ($urandom_range(99) < 60);
            in_data   = {$urandom, $urandom, $urandom};

            m_ov = (mq.size() > 0);
            m_ir = (mq.size() < 2);
            pop  = m_ov && out_ready;
            push = in_valid && m_ir;
            if (stall_clr) begin
                m_cnt = 0; m_cnt4 = 0;
            end else if (m_ov && !out_ready && !flush) begin
                if (m_cnt  < 65535) m_cnt++;
                if (m_cnt4 < 15)    m_cnt4++;
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (pop)  void'(mq.pop_front());
                if (push) mq.push_back(in_data);
            end

            cyc();

            m_ov = (mq.size() > 0);
            m_ir = (mq.size() < 2);
            m_od = m_ov ? mq[0] : BUB;
            chk("rnd_out_valid", 96'(out_valid), 96'(m_ov));
            chk("rnd_in_ready",  96'(in_ready),  96'(m_ir));
            chk("rnd_out_data",  out_data, m_od);
            chk("rnd_stall_cnt", 96'(stall_cnt), 96'(m_cnt));
            chk("rnd_stall_cnt4", 96'(stall_cnt4), 96'(m_cnt4));
            chk("inv_skid_implies_valid", 96'(!in_ready && !out_valid), 96'(0));
            chk("inv_bubble_when_invalid", 96'(!out_valid && (out_data !== BUB)), 96'(0));
        end
        $display("random run: 10000 cycles, model holds %0d entries at end", mq.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
